// File: rtl/stopwatch_pkg.sv
// Shared FSM encodings, time struct and digit limits for the lap stopwatch.
// time_sub is only referenced when LAP_SPLIT_EN is defined.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [6:0] CS_MAX = 7'd99;
    localparam logic [5:0] SM_MAX = 6'd59;

    typedef struct packed {
        logic [5:0] hour;
        logic [5:0] minute;
        logic [5:0] second;
        logic [6:0] m_sec;
    } sw_time_t;

    // Mixed-radix a - b with borrows rippling cs -> s -> m -> h; hours wrap modulo hour_wrap.
    function automatic sw_time_t time_sub(input sw_time_t a, input sw_time_t b, input int hour_wrap);
        sw_time_t diff;
        int cs;
        int sec;
        int mins;
        int hrs;
        cs   = int'(a.m_sec)  - int'(b.m_sec);
        sec  = int'(a.second) - int'(b.second);
        mins = int'(a.minute) - int'(b.minute);
        hrs  = int'(a.hour)   - int'(b.hour);
        if (cs < 0) begin
            cs  = cs + 100;
            sec = sec - 1;
        end
        if (sec < 0) begin
            sec  = sec + 60;
            mins = mins - 1;
        end
        if (mins < 0) begin
            mins = mins + 60;
            hrs  = hrs - 1;
        end
        if (hrs < 0) begin
            hrs = hrs + hour_wrap;
        end
        diff.hour   = 6'(hrs);
        diff.minute = 6'(mins);
        diff.second = 6'(sec);
        diff.m_sec  = 7'(cs);
        return diff;
    endfunction

endpackage

// File: rtl/time_counter_chain.sv
// Centisecond prescaler feeding a cascaded cs/s/m/h counter; every digit
// steps on the same edge so no partial carry is ever visible.
module time_counter_chain
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int HOUR_WRAP   = 24
) (
    input  logic     clock,
    input  logic     reset_n,
    input  logic     en,
    input  logic     clr,
    output sw_time_t cur_time,
    output sw_time_t next_time,
    output logic     tick
);

    localparam int DIV = (CLK_FREQ_HZ / 100 > 0) ? CLK_FREQ_HZ / 100 : 1;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_LAST   = PW'(DIV - 1);
    localparam logic [5:0]    HOUR_LAST = 6'(HOUR_WRAP - 1);

    logic [PW-1:0] prescaler;

    assign tick = en && (prescaler == PS_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else if (clr) begin
            prescaler <= '0;
        end else if (en) begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
        end
    end

    // next_time is also the lap snapshot source when a tick lands on the lap edge.
    always_comb begin
        next_time = cur_time;
        if (cur_time.m_sec != CS_MAX) begin
            next_time.m_sec = cur_time.m_sec + 7'd1;
        end else begin
            next_time.m_sec = '0;
            if (cur_time.second != SM_MAX) begin
                next_time.second = cur_time.second + 6'd1;
            end else begin
                next_time.second = '0;
                if (cur_time.minute != SM_MAX) begin
                    next_time.minute = cur_time.minute + 6'd1;
                end else begin
                    next_time.minute = '0;
                    next_time.hour   = (cur_time.hour >= HOUR_LAST) ? '0 : cur_time.hour + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_time <= '0;
        end else if (clr) begin
            cur_time <= '0;
        end else if (tick) begin
            cur_time <= next_time;
        end
    end

endmodule

// File: rtl/lap_stopwatch_core.sv
// Stopwatch with run/pause/zero FSM, lap capture buffer and lap recall.
// Define LAP_SPLIT_EN to store split times instead of cumulative times in the lap buffer.
module lap_stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int LAP_DEPTH   = 8,
    parameter int HOUR_WRAP   = 24
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start_pause,
    input  logic                       zero,
    input  logic                       lap,
    input  logic                       clear,
    output logic [5:0]                 hour,
    output logic [5:0]                 minute,
    output logic [5:0]                 second,
    output logic [6:0]                 m_sec,
    output logic                       running,
    output logic                       recall_active,
    output logic [$clog2(LAP_DEPTH):0] lap_count,
    output logic                       lap_overflow
);

    localparam int AW = $clog2(LAP_DEPTH);
    localparam logic [AW:0] LAP_FULL = (AW + 1)'(LAP_DEPTH);
    localparam logic [AW:0] LAP_ONE  = (AW + 1)'(1);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic          do_start;
    logic          do_zero;
    logic          do_lap;
    logic          do_clear;
    logic          chain_en;
    logic          chain_clr;
    logic          tick;
    logic          lap_write;
    logic          lap_drop;
    logic          recall_step;
    logic          rd_last;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    sw_time_t      live_time;
    sw_time_t      next_time;
    sw_time_t      snap;
    sw_time_t      lap_entry;
    sw_time_t      display;
    sw_time_t      lap_mem [LAP_DEPTH];

    // Only the highest-priority pulse in a cycle survives: start > zero > lap > clear.
    assign do_start = start_pause;
    assign do_zero  = zero & ~start_pause;
    assign do_lap   = lap & ~start_pause & ~zero;
    assign do_clear = clear & ~start_pause & ~zero & ~lap;

    assign chain_en  = (state == ST_RUN);
    assign chain_clr = (state == ST_PAUSE) && do_zero;

    time_counter_chain #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .HOUR_WRAP   (HOUR_WRAP)
    ) u_chain (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (chain_en),
        .clr       (chain_clr),
        .cur_time  (live_time),
        .next_time (next_time),
        .tick      (tick)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (do_start) state_next = ST_RUN;
            ST_RUN:   if (do_start) state_next = ST_PAUSE;
            ST_PAUSE: begin
                if (do_start) begin
                    state_next = ST_RUN;
                end else if (do_zero) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == ST_RUN);
        end
    end

    assign snap        = tick ? next_time : live_time;
    assign lap_write   = do_lap && (state == ST_RUN) && (lap_count != LAP_FULL);
    assign lap_drop    = do_lap && (state == ST_RUN) && (lap_count == LAP_FULL);
    assign recall_step = do_lap && (state != ST_RUN) && (lap_count != '0);
    assign rd_last     = ({1'b0, rd_ptr} == (lap_count - LAP_ONE));

`ifdef LAP_SPLIT_EN
    sw_time_t last_lap;

    // Reference point for splits restarts whenever the timer is zeroed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_lap <= '0;
        end else if (chain_clr) begin
            last_lap <= '0;
        end else if (lap_write) begin
            last_lap <= snap;
        end
    end

    assign lap_entry = time_sub(snap, last_lap, HOUR_WRAP);
`else
    assign lap_entry = snap;
`endif

    always_ff @(posedge clock) begin
        if (lap_write) begin
            lap_mem[wr_ptr] <= lap_entry;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lap_count     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            lap_overflow  <= 1'b0;
            recall_active <= 1'b0;
        end else if (do_clear) begin
            lap_count     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            lap_overflow  <= 1'b0;
            recall_active <= 1'b0;
        end else begin
            if (lap_write) begin
                lap_count <= lap_count + LAP_ONE;
                wr_ptr    <= wr_ptr + AW'(1);
            end
            if (lap_drop) begin
                lap_overflow <= 1'b1;
            end
            // First recall pulse only enters recall on the oldest entry; later ones step.
            if (do_start || do_zero) begin
                recall_active <= 1'b0;
                rd_ptr        <= '0;
            end else if (recall_step) begin
                if (!recall_active) begin
                    recall_active <= 1'b1;
                end else begin
                    rd_ptr <= rd_last ? '0 : rd_ptr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            display <= '0;
        end else begin
            display <= recall_active ? lap_mem[rd_ptr] : live_time;
        end
    end

    assign hour   = display.hour;
    assign minute = display.minute;
    assign second = display.second;
    assign m_sec  = display.m_sec;

endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Self-checking bench for lap_stopwatch_core: directed steps plus a random phase,
// compared each cycle against a centisecond-count model of the stopwatch.
module tb_lap_stopwatch_core;
    import stopwatch_pkg::*;

    localparam int CLK_FREQ_HZ = 1000;
    localparam int LAP_DEPTH   = 4;
    localparam int HOUR_WRAP   = 24;
    localparam int DIV         = CLK_FREQ_HZ / 100;
    localparam int DAY_CS      = HOUR_WRAP * 360000;
    localparam int M_IDLE      = 0;
    localparam int M_RUN       = 1;
    localparam int M_PAUSE     = 2;
`ifdef LAP_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       start_pause = 1'b0;
    logic       zero = 1'b0;
    logic       lap = 1'b0;
    logic       clear = 1'b0;
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [6:0] m_sec;
    logic       running;
    logic       recall_active;
    logic [2:0] lap_count;
    logic       lap_overflow;

    int errors = 0;
    int checks = 0;

    int m_mode;
    int m_ps;
    int m_cs;
    int m_disp;
    int m_rd;
    int m_last;
    bit m_running;
    bit m_recall;
    bit m_ovf;
    int m_laps[$];

    always #5 clock = ~clock;

    lap_stopwatch_core #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .LAP_DEPTH   (LAP_DEPTH),
        .HOUR_WRAP   (HOUR_WRAP)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start_pause   (start_pause),
        .zero          (zero),
        .lap           (lap),
        .clear         (clear),
        .hour          (hour),
        .minute        (minute),
        .second        (second),
        .m_sec         (m_sec),
        .running       (running),
        .recall_active (recall_active),
        .lap_count     (lap_count),
        .lap_overflow  (lap_overflow)
    );

    task automatic model_reset();
        m_mode = M_IDLE;
        m_ps = 0;
        m_cs = 0;
        m_disp = 0;
        m_rd = 0;
        m_last = 0;
        m_running = 1'b0;
        m_recall = 1'b0;
        m_ovf = 1'b0;
        m_laps.delete();
    endtask

    // Time is one integer of centiseconds modulo a day; digits are derived only for comparison.
    task automatic model_step(input bit sp, input bit z, input bit l, input bit c);
        bit ds;
        bit dz;
        bit dl;
        bit dc;
        bit tk;
        int snap;
        int entry;
        ds = sp;
        dz = z && !sp;
        dl = l && !sp && !z;
        dc = c && !sp && !z && !l;
        m_disp = m_recall ? m_laps[m_rd] : m_cs;
        tk = (m_mode == M_RUN) && (m_ps == DIV - 1);
        snap = tk ? (m_cs + 1) % DAY_CS : m_cs;
        entry = SPLIT_EN ? (snap - m_last + DAY_CS) % DAY_CS : snap;
        if (dc) begin
            m_laps.delete();
            m_ovf = 1'b0;
            m_recall = 1'b0;
            m_rd = 0;
        end else begin
            if (dl && m_mode == M_RUN) begin
                if (m_laps.size() == LAP_DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    m_laps.push_back(entry);
                    m_last = snap;
                end
            end
            if (ds || dz) begin
                m_recall = 1'b0;
                m_rd = 0;
            end else if (dl && m_mode != M_RUN && m_laps.size() > 0) begin
                if (!m_recall) m_recall = 1'b1;
                else m_rd = (m_rd + 1) % m_laps.size();
            end
        end
        if (m_mode == M_RUN) begin
            if (tk) begin
                m_cs = snap;
                m_ps = 0;
            end else begin
                m_ps = m_ps + 1;
            end
        end else if (m_mode == M_PAUSE && dz) begin
            m_cs = 0;
            m_ps = 0;
            m_last = 0;
        end
        if (m_mode == M_IDLE && ds) m_mode = M_RUN;
        else if (m_mode == M_RUN && ds) m_mode = M_PAUSE;
        else if (m_mode == M_PAUSE && ds) m_mode = M_RUN;
        else if (m_mode == M_PAUSE && dz) m_mode = M_IDLE;
        m_running = (m_mode == M_RUN);
    endtask

    task automatic check_val(input string tag, input logic [31:0] observed, input int expected);
        checks++;
        assert (observed === 32'(expected)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_output(input string tag);
        check_val({tag, ".hour"}, 32'(hour), m_disp / 360000);
        check_val({tag, ".minute"}, 32'(minute), (m_disp / 6000) % 60);
        check_val({tag, ".second"}, 32'(second), (m_disp / 100) % 60);
        check_val({tag, ".m_sec"}, 32'(m_sec), m_disp % 100);
        check_val({tag, ".running"}, 32'(running), int'(m_running));
        check_val({tag, ".recall"}, 32'(recall_active), int'(m_recall));
        check_val({tag, ".lap_count"}, 32'(lap_count), m_laps.size());
        check_val({tag, ".overflow"}, 32'(lap_overflow), int'(m_ovf));
    endtask

    task automatic apply_stimulus(input bit sp, input bit z, input bit l, input bit c, input string tag);
        @(negedge clock);
        start_pause = sp;
        zero = z;
        lap = l;
        clear = c;
        @(posedge clock);
        #1;
        start_pause = 1'b0;
        zero = 1'b0;
        lap = 1'b0;
        clear = 1'b0;
        model_step(sp, z, l, c);
        check_output(tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        repeat (n) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        sw_time_t ft;
        bit found;
        int kept;
        int exp_cs;

        model_reset();
        #2 reset_n = 1'b0;
        #1;
        check_output("reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "start");
        idle_cycles(1001, "run_1s");
        check_val("one_second.second", 32'(second), 1);
        check_val("one_second.m_sec", 32'(m_sec), 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "pause");
        idle_cycles(50, "paused");
        check_val("paused.second", 32'(second), 1);
        check_val("paused.m_sec", 32'(m_sec), 0);
        check_val("paused.running", 32'(running), 0);

        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "zero_pause");
        idle_cycles(1, "zero_pause_show");
        check_val("zeroed.second", 32'(second), 0);
        check_val("zeroed.m_sec", 32'(m_sec), 0);

        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "lap_start");
        for (int k = 0; k < 5; k++) begin
            idle_cycles(99, "lap_run");
            apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, "lap_take");
        end
        check_val("laps.count", 32'(lap_count), 4);
        check_val("laps.overflow", 32'(lap_overflow), 1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "lap_pause");
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, "recall_step");
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, "recall_show");
            exp_cs = SPLIT_EN ? 10 : 10 * ((k % 4) + 1);
            check_val("recall.active", 32'(recall_active), 1);
            check_val("recall.m_sec", 32'(m_sec), exp_cs);
            check_val("recall.second", 32'(second), 0);
        end

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, "clear");
        idle_cycles(1, "clear_show");
        check_val("clear.count", 32'(lap_count), 0);
        check_val("clear.overflow", 32'(lap_overflow), 0);
        check_val("clear.recall", 32'(recall_active), 0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, "lap_empty");
        check_val("lap_empty.recall", 32'(recall_active), 0);

        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "resume");
        idle_cycles(23, "resume_run");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "zero_in_run");
        idle_cycles(5, "zero_in_run_after");
        check_val("zero_in_run.running", 32'(running), 1);

        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "pause2");
        idle_cycles(3, "pause2_hold");
        kept = m_cs;
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, "start_and_zero");
        idle_cycles(1, "start_and_zero_show");
        check_val("start_zero.running", 32'(running), 1);
        check_val("start_zero.m_sec", 32'(m_sec), kept % 100);
        check_val("start_zero.second", 32'(second), (kept / 100) % 60);

        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "pause3");
        ft.hour = 6'd23;
        ft.minute = 6'd59;
        ft.second = 6'd59;
        ft.m_sec = 7'd99;
        force dut.u_chain.cur_time = ft;
        m_cs = DAY_CS - 1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, "preload");
        release dut.u_chain.cur_time;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, "preload_hold");
        check_val("preload.hour", 32'(hour), 23);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "wrap_start");
        found = 1'b0;
        for (int i = 0; i < DIV + 2 && !found; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, "wrap_run");
            if (m_cs == 0) found = 1'b1;
        end
        check_val("wrap_seen", 32'(found), 1);
        idle_cycles(1, "wrap_show");
        check_val("wrap.hour", 32'(hour), 0);
        check_val("wrap.minute", 32'(minute), 0);
        check_val("wrap.second", 32'(second), 0);
        check_val("wrap.m_sec", 32'(m_sec), 0);

        for (int i = 0; i < 3000; i++) begin
            bit sp;
            bit z;
            bit l;
            bit c;
            sp = ($urandom_range(0, 49) == 0);
            z  = ($urandom_range(0, 29) == 0);
            l  = ($urandom_range(0, 9) == 0);
            c  = ($urandom_range(0, 79) == 0);
            apply_stimulus(sp, z, l, c, "random");
        end

        if (m_mode != M_RUN) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "final_start");
        idle_cycles(30, "final_run");
        reset_n = 1'b0;
        #1;
        check_val("async_reset.hour", 32'(hour), 0);
        check_val("async_reset.minute", 32'(minute), 0);
        check_val("async_reset.second", 32'(second), 0);
        check_val("async_reset.m_sec", 32'(m_sec), 0);
        check_val("async_reset.running", 32'(running), 0);
        check_val("async_reset.recall", 32'(recall_active), 0);
        check_val("async_reset.count", 32'(lap_count), 0);
        check_val("async_reset.overflow", 32'(lap_overflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
